// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types, MDU opcodes and hi/lo funct codes for the muldiv unit
package muldiv_unit_pkg;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MTHI = 6'h11;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MTLO = 6'h13;
  function automatic logic is_signed_op(mdu_op_t op);
    return !op[0];
  endfunction
  function automatic logic is_div_op(mdu_op_t op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request/response bundle between the pipeline and the muldiv unit
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             startE;
  mdu_op_t          opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             abortE;
  logic             mthiE;
  logic             mtloE;
  logic [WIDTH-1:0] wdataE;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  modport master(
    output startE, opE, srcaE, srcbE, abortE, mthiE, mtloE, wdataE,
    input  hi, lo, busy
  );
  modport slave(
    input  startE, opE, srcaE, srcbE, abortE, mthiE, mtloE, wdataE,
    output hi, lo, busy
  );
endinterface

// File: rtl/muldiv_unit_datapath.sv
// mdu_datapath: magnitude shift-add multiplier / restoring divider with final sign fixup
module mdu_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               div_q, div_d, negq_q, negq_d, negr_q, negr_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b, up, lw;
  logic [WIDTH:0]     sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sa = is_signed_op(op_i) & a_i[WIDTH-1];
    sb = is_signed_op(op_i) & b_i[WIDTH-1];
    abs_a = sa ? -a_i : a_i;
    abs_b = sb ? -b_i : b_i;
    up = acc_q[2*WIDTH-1:WIDTH];
    lw = acc_q[WIDTH-1:0];
    sum = {1'b0, up} + (lw[0] ? {1'b0, m_q} : '0);
    shl = {up, lw[WIDTH-1]};
    diff = shl - {1'b0, m_q};
    prod = negq_q ? -acc_q : acc_q;
    m_d = load_i ? (is_div_op(op_i) ? abs_b : abs_a) : m_q;
    acc_d = load_i ? {{WIDTH{1'b0}}, is_div_op(op_i) ? abs_a : abs_b}
          : !step_i ? acc_q
          : !div_q ? {sum, lw[WIDTH-1:1]}
          : diff[WIDTH] ? {shl[WIDTH-1:0], lw[WIDTH-2:0], 1'b0}
          : {diff[WIDTH-1:0], lw[WIDTH-2:0], 1'b1};
    div_d = load_i ? is_div_op(op_i) : div_q;
    // a zero divisor leaves the all-ones quotient unsigned
    negq_d = load_i ? ((sa ^ sb) & !(is_div_op(op_i) && b_i == '0)) : negq_q;
    negr_d = load_i ? (is_div_op(op_i) & sa) : negr_q;
    res_hi_o = div_q ? (negr_q ? -up : up) : prod[2*WIDTH-1:WIDTH];
    res_lo_o = div_q ? (negq_q ? -lw : lw) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      acc_q <= '0;
      div_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      m_q <= m_d;
      acc_q <= acc_d;
      div_q <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit owning the architectural HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  mdu_state_t       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
  logic             load, step;
  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .step_i  (step),
    .op_i    (bus.opE),
    .a_i     (bus.srcaE),
    .b_i     (bus.srcbE),
    .res_hi_o(res_hi),
    .res_lo_o(res_lo)
  );
  // abort beats MTHI/MTLO, which beat completion, which beats a new start
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    load = 1'b0;
    step = 1'b0;
    if (bus.abortE) begin
      state_d = IDLE;
    end else if (bus.mthiE || bus.mtloE) begin
      hi_d = bus.mthiE ? bus.wdataE : hi_q;
      lo_d = bus.mtloE ? bus.wdataE : lo_q;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          load = bus.startE;
          cnt_d = bus.startE ? CNTW'(WIDTH) : cnt_q;
          state_d = bus.startE ? RUN : IDLE;
        end
        RUN: begin
          step = 1'b1;
          cnt_d = cnt_q - 1'b1;
          state_d = (cnt_q == CNTW'(1)) ? FIX : RUN;
        end
        default: begin
          hi_d = res_hi;
          lo_d = res_lo;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit_if #(.WIDTH(8)) bus8 ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus.slave));
  muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst), .bus(bus8.slave));
  int n_cmp = 0;
  int n_bad = 0;
  logic chk = 1'b0;
  logic [W-1:0] e_hi = '0, e_lo = '0, r_hi = '0, r_lo = '0;
  logic e_busy = 1'b0;
  int m_left = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    longint sp;
    logic [63:0] up;
    h = '0;
    l = '0;
    if (op == 2'b00) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      {h, l} = sp;
    end else if (op == 2'b01) begin
      up = 64'(a) * 64'(b);
      {h, l} = up;
    end else if (b == '0) begin
      h = a;
      l = '1;
    end else if (op == 2'b10) begin
      sp = longint'($signed(a));
      h = W'(sp % longint'($signed(b)));
      l = W'(sp / longint'($signed(b)));
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction
  // architectural model: result appears W+1 edges after an accepted start
  task automatic tick();
    logic [W-1:0] nh, nl;
    int nleft;
    nh = e_hi;
    nl = e_lo;
    nleft = m_left;
    if (bus.abortE) nleft = 0;
    else if (bus.mthiE || bus.mtloE) begin
      if (bus.mthiE) nh = bus.wdataE;
      if (bus.mtloE) nl = bus.wdataE;
      nleft = 0;
    end else if (nleft > 0) begin
      nleft--;
      if (nleft == 0) begin
        nh = r_hi;
        nl = r_lo;
      end
    end else if (bus.startE) begin
      ref_op(bus.opE, bus.srcaE, bus.srcbE, r_hi, r_lo);
      nleft = W + 1;
    end
    @(posedge clk);
    #1;
    e_hi = nh;
    e_lo = nl;
    m_left = nleft;
    e_busy = (nleft > 0);
  endtask
  always @(negedge clk) begin
    if (chk) begin
      check("hi", 64'(bus.hi), 64'(e_hi));
      check("lo", 64'(bus.lo), 64'(e_lo));
      check("busy", 64'(bus.busy), 64'(e_busy));
    end
  end
  task automatic start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.opE = mdu_op_t'(op);
    bus.srcaE = a;
    bus.srcbE = b;
    bus.startE = 1'b1;
    tick();
    bus.startE = 1'b0;
  endtask
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    cyc = 0;
    start(op, a, b);
    while (bus.busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask
  task automatic mt(input logic to_hi, input logic [W-1:0] v);
    bus.mthiE = to_hi;
    bus.mtloE = !to_hi;
    bus.wdataE = v;
    tick();
    bus.mthiE = 1'b0;
    bus.mtloE = 1'b0;
  endtask
  task automatic expect_hl(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
    check({name, "_hi"}, 64'(bus.hi), 64'(h));
    check({name, "_lo"}, 64'(bus.lo), 64'(l));
  endtask
  initial begin
    int c;
    logic [W-1:0] h, l, a, b;
    logic [1:0] op;
    {bus.startE, bus.abortE, bus.mthiE, bus.mtloE} = '0;
    bus.opE = MDU_MULT;
    {bus.srcaE, bus.srcbE, bus.wdataE} = '0;
    {bus8.startE, bus8.abortE, bus8.mthiE, bus8.mtloE} = '0;
    bus8.opE = MDU_MULT;
    {bus8.srcaE, bus8.srcbE, bus8.wdataE} = '0;
    ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    check("model_div_ovf", {h, l}, 64'h0000_0000_8000_0000);
    ref_op(2'b00, 32'd7, 32'hFFFF_FFFD, h, l);
    check("model_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    expect_hl("reset", '0, '0);
    rst = 1'b0;
    chk = 1'b1;
    bus8.opE = MDU_MULTU;
    bus8.srcaE = 8'hFF;
    bus8.srcbE = 8'hFF;
    bus8.startE = 1'b1;
    tick();
    bus8.startE = 1'b0;
    repeat (8) tick();
    check("w8_busy_late", 64'(bus8.busy), 64'd1);
    tick();
    check("w8_busy_done", 64'(bus8.busy), 64'd0);
    check("w8_hi", 64'(bus8.hi), 64'hFE);
    check("w8_lo", 64'(bus8.lo), 64'h01);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, c);
    check("mult_busy_cycles", 64'(c), 64'd33);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'b01, '1, '1, c);
    expect_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, c);
    expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd0, c);
    check("divz_busy_cycles", 64'(c), 64'd33);
    expect_hl("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, c);
    expect_hl("div_zero_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c);
    expect_hl("div_ovf", 32'h0, 32'h8000_0000);
    mt(1'b1, 32'hAAAA);
    mt(1'b0, 32'h5555);
    start(2'b00, 32'd5, 32'd5);
    repeat (9) tick();
    bus.abortE = 1'b1;
    bus.startE = 1'b1;
    tick();
    {bus.abortE, bus.startE} = '0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    expect_hl("abort", 32'hAAAA, 32'h5555);
    tick();
    check("abort_start_dropped", 64'(bus.busy), 64'd0);
    start(2'b00, 32'd6, 32'd7);
    repeat (5) tick();
    start(2'b01, 32'd3, 32'd3);
    while (bus.busy && c < 200) begin
      c++;
      tick();
    end
    expect_hl("start_ignored", 32'd0, 32'd42);
    start(2'b11, 32'd1000, 32'd7);
    repeat (5) tick();
    mt(1'b0, 32'h1234);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    expect_hl("mtlo_mid", 32'd0, 32'h1234);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      run_op(op, a, b, c);
      check("rand_busy_cycles", 64'(c), 64'd33);
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
    end
    start(2'b01, $urandom, $urandom);
    repeat (10) tick();
    @(negedge clk);
    chk = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    expect_hl("rst_mid", '0, '0);
    e_hi = '0;
    e_lo = '0;
    m_left = 0;
    e_busy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk = 1'b1;
    tick();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    expect_hl("after_rst", 32'd0, 32'd1);
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
